// File: rtl/trace_pkg.sv
// Shared types and constants for the retire-trace capture buffer.
package trace_pkg;

  // Capture FSM encoding; also the value presented on the debug state port.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_READ  = 2'b11
  } state_e;

  // Trigger source selection.
  typedef enum logic [1:0] {
    TRIG_PC     = 2'b00,
    TRIG_RESULT = 2'b01,
    TRIG_EXT    = 2'b10,
    TRIG_IMM    = 2'b11
  } trig_mode_e;

  // Flag vector layout {zero,carry,negative,overflow}.
  localparam int FLAG_W = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // One stored entry is {pc, instr, result, flags}.
  function automatic int entry_w(input int xlen);
    return 3 * xlen + FLAG_W;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Flop-based trace storage: one synchronous write port, one asynchronous read port.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 100,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Store one entry per enabled cycle; contents need no reset because readout is gated.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trace_capture_buffer.sv
// Retire-trace recorder: circular capture while armed, trigger plus post window,
// then oldest-first drain over a valid/ready port.
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic [1:0]      trig_mode,
  input  logic [XLEN-1:0] trig_value,
  input  logic            trig_ext,
  input  logic [AW-1:0]   post_count,
  input  logic            retire_valid,
  input  logic [XLEN-1:0] retire_pc,
  input  logic [XLEN-1:0] retire_instr,
  input  logic [XLEN-1:0] retire_result,
  input  logic [3:0]      retire_flags,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [XLEN-1:0] rd_pc,
  output logic [XLEN-1:0] rd_instr,
  output logic [XLEN-1:0] rd_result,
  output logic [3:0]      rd_flags,
  output logic            rd_last,
  output logic [1:0]      state,
  output logic [AW:0]     count,
  output logic [AW-1:0]   trig_index,
  output logic            wrapped
);

  localparam int EW = entry_w(XLEN);

  state_e          r_state, w_state_nxt;
  trig_mode_e      r_mode;
  logic [XLEN-1:0] r_value;
  logic [AW-1:0]   r_post, r_remaining;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr, r_trig_index;
  logic [AW:0]     r_count, r_left;
  logic            r_wrapped;

  logic            w_we, w_hit, w_xfer, w_enter_read;
  logic [AW-1:0]   w_wr_ptr_nxt;
  logic [AW:0]     w_count_nxt;
  logic            w_full, w_wrapped_nxt;
  logic [EW-1:0]   w_rdata;
  logic [3:0]      w_flags;

  // Capture only while armed or in the post window; arm and reset take priority.
  assign w_we          = retire_valid && !arm && !rst &&
                         (r_state == S_ARMED || r_state == S_POST);
  assign w_wr_ptr_nxt  = r_wr_ptr + AW'(1);
  assign w_full        = (r_count == (AW+1)'(DEPTH));
  assign w_count_nxt   = w_full ? r_count : r_count + (AW+1)'(1);
  assign w_wrapped_nxt = r_wrapped || w_full;

  // Readout handshake: an entry moves on any cycle with rd_valid & rd_ready; while
  // rd_valid is high and rd_ready low the presented entry and pointer do not change.
  assign w_xfer       = rd_valid && rd_ready;
  assign w_enter_read = (r_state != S_READ) && (w_state_nxt == S_READ);

  // Trigger compare against the latched mode/value; only used together with w_we.
  always_comb begin
    w_hit = 1'b0;
    case (r_mode)
      TRIG_PC:     w_hit = (retire_pc == r_value);
      TRIG_RESULT: w_hit = (retire_result == r_value);
      TRIG_EXT:    w_hit = trig_ext;
      TRIG_IMM:    w_hit = 1'b1;
      default:     w_hit = 1'b0;
    endcase
  end

  // Next-state logic; arm restarts capture from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: if (w_we && w_hit) w_state_nxt = (r_post == '0) ? S_READ : S_POST;
        S_POST:  if (w_we && r_remaining == AW'(1)) w_state_nxt = S_READ;
        S_READ:  if (w_xfer && r_left == (AW+1)'(1)) w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Pointers, occupancy, trigger bookkeeping and latched configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_left       <= '0;
      r_wrapped    <= 1'b0;
      r_trig_index <= '0;
      r_remaining  <= '0;
      r_post       <= '0;
      r_mode       <= TRIG_PC;
      r_value      <= '0;
    end else if (arm) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_post    <= post_count;
      r_mode    <= trig_mode_e'(trig_mode);
      r_value   <= trig_value;
    end else begin
      if (w_we) begin
        r_wr_ptr  <= w_wr_ptr_nxt;
        r_count   <= w_count_nxt;
        r_wrapped <= w_wrapped_nxt;
        if (r_state == S_ARMED && w_hit) begin
          r_trig_index <= r_wr_ptr;
          r_remaining  <= r_post;
        end
        if (r_state == S_POST) r_remaining <= r_remaining - AW'(1);
      end
      // Oldest entry sits at the write pointer once the ring has wrapped.
      if (w_enter_read) begin
        r_rd_ptr <= w_wrapped_nxt ? w_wr_ptr_nxt : '0;
        r_left   <= w_count_nxt;
      end else if (w_xfer) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_left   <= r_left - (AW+1)'(1);
      end
    end
  end

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata ({retire_pc, retire_instr, retire_result, retire_flags}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign w_flags = w_rdata[FLAG_W-1:0];

  assign rd_valid   = (r_state == S_READ);
  assign rd_last    = rd_valid && (r_left == (AW+1)'(1));
  assign rd_pc      = rd_valid ? w_rdata[EW-1 -: XLEN]      : '0;
  assign rd_instr   = rd_valid ? w_rdata[EW-1-XLEN -: XLEN] : '0;
  assign rd_result  = rd_valid ? w_rdata[FLAG_W +: XLEN]    : '0;
  assign rd_flags   = rd_valid ? {w_flags[FLAG_Z], w_flags[FLAG_C],
                                  w_flags[FLAG_N], w_flags[FLAG_V]} : 4'b0;
  assign state      = r_state;
  assign count      = r_count;
  assign trig_index = r_trig_index;
  assign wrapped    = r_wrapped;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Bench for trace_capture_buffer (DEPTH=8): directed and randomized captures
// compared against a list-based model of the retire stream.
module tb_trace_capture_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int EW    = 3 * XLEN + 4;

  logic            clk = 1'b0;
  logic            rst, arm, trig_ext, retire_valid, rd_ready;
  logic [1:0]      trig_mode;
  logic [XLEN-1:0] trig_value, retire_pc, retire_instr, retire_result;
  logic [AW-1:0]   post_count;
  logic [3:0]      retire_flags;
  logic            rd_valid, rd_last, wrapped;
  logic [XLEN-1:0] rd_pc, rd_instr, rd_result;
  logic [3:0]      rd_flags;
  logic [1:0]      state;
  logic [AW:0]     count;
  logic [AW-1:0]   trig_index;

  int n_checks = 0;
  int n_errors = 0;

  // Model: every retire the bench expects to be captured, in order.
  logic [EW-1:0] m_list[$];
  logic [EW-1:0] exp_q[$];
  int m_phase;     // 0 idle, 1 armed, 2 post-window, 3 readout
  int m_trig_pos;
  int m_rem;
  int m_count;

  trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_mode(trig_mode), .trig_value(trig_value),
    .trig_ext(trig_ext), .post_count(post_count), .retire_valid(retire_valid),
    .retire_pc(retire_pc), .retire_instr(retire_instr), .retire_result(retire_result),
    .retire_flags(retire_flags), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_result(rd_result), .rd_flags(rd_flags),
    .rd_last(rd_last), .state(state), .count(count), .trig_index(trig_index),
    .wrapped(wrapped)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arm, then feed retires until the model says the post window is complete.
  task automatic capture(input logic [1:0] mode, input logic [31:0] value, input int post,
                         input logic [31:0] pc_base, input logic [31:0] res_base,
                         input int ext_k, input int limit, input int density);
    int k, cyc, n, first;
    bit hit;
    logic [31:0] pc, res;
    arm = 1'b1; trig_mode = mode; trig_value = value; post_count = post[AW-1:0];
    // A retire in the arm cycle that would otherwise match must be dropped.
    retire_valid = 1'b1; retire_pc = value; retire_result = value; trig_ext = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0; retire_valid = 1'b0; trig_ext = 1'b0;
    m_list.delete(); exp_q.delete();
    m_phase = 1; m_trig_pos = -1; m_rem = 0;
    check_eq("arm_state", state, 1);
    check_eq("arm_count", count, 0);
    check_eq("arm_wrapped", wrapped, 0);
    k = 0; cyc = 0;
    while (m_phase != 3 && k < limit && cyc < 400) begin
      if ($urandom_range(1, 100) <= density) begin
        pc = pc_base + 32'(4 * k);
        res = res_base + 32'(k);
        retire_valid = 1'b1; retire_pc = pc; retire_instr = $urandom;
        retire_result = res; retire_flags = 4'($urandom_range(0, 15));
        trig_ext = (k == ext_k);
        m_list.push_back({retire_pc, retire_instr, retire_result, retire_flags});
        if (m_phase == 1) begin
          case (mode)
            2'd0:    hit = (pc == value);
            2'd1:    hit = (res == value);
            2'd2:    hit = (k == ext_k);
            default: hit = 1'b1;
          endcase
          if (hit) begin
            m_trig_pos = m_list.size() - 1;
            if (post == 0) m_phase = 3;
            else begin m_rem = post; m_phase = 2; end
          end
        end else begin
          m_rem--;
          if (m_rem == 0) m_phase = 3;
        end
        k++;
      end else begin
        retire_valid = 1'b0; retire_pc = $urandom; retire_result = $urandom;
        trig_ext = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; cyc++;
      check_eq("cap_state", state, m_phase);
    end
    retire_valid = 1'b0; trig_ext = 1'b0;
    n = m_list.size();
    m_count = (n > DEPTH) ? DEPTH : n;
    check_eq("cap_count", count, m_count);
    check_eq("cap_wrapped", wrapped, n > DEPTH);
    if (m_trig_pos >= 0) check_eq("trig_index", trig_index, m_trig_pos % DEPTH);
    first = (n > DEPTH) ? n - DEPTH : 0;
    for (int i = first; i < n; i++) exp_q.push_back(m_list[i]);
  endtask

  // Drain up to max_beats entries; ready_mode 0 always, 1 = 1,0,0,1,1 pattern, 2 random.
  task automatic drain(input int ready_mode, input int max_beats);
    int cyc, beats;
    bit held;
    logic [EW-1:0] hv, got, e;
    cyc = 0; beats = 0; held = 1'b0;
    while (exp_q.size() > 0 && beats < max_beats && cyc < 200) begin
      case (ready_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 5 == 0) || (cyc % 5 >= 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      retire_valid = 1'($urandom_range(0, 1)); retire_pc = $urandom;
      trig_ext = 1'($urandom_range(0, 1));
      got = {rd_pc, rd_instr, rd_result, rd_flags};
      check_eq("rd_valid", rd_valid, 1);
      if (!rd_valid) break;
      if (held) check_eq("rd_hold", got, hv);
      if (rd_ready) begin
        e = exp_q.pop_front();
        check_eq("rd_data", got, e);
        check_eq("rd_last", rd_last, exp_q.size() == 0);
        beats++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hv = got;
      end
      @(posedge clk); #1; cyc++;
    end
    rd_ready = 1'b0; retire_valid = 1'b0; trig_ext = 1'b0;
    if (beats < max_beats) begin
      check_eq("drain_left", exp_q.size(), 0);
      check_eq("end_state", state, 0);
      check_eq("end_rd_valid", rd_valid, 0);
      check_eq("end_rd_pc", rd_pc, 0);
      check_eq("end_rd_last", rd_last, 0);
      check_eq("end_count", count, m_count);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trig_mode = 2'b00; trig_value = '0; trig_ext = 1'b0;
    post_count = '0; retire_valid = 1'b0; retire_pc = '0; retire_instr = '0;
    retire_result = '0; retire_flags = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", state, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_wrapped", wrapped, 0);
    check_eq("rst_trig_index", trig_index, 0);
    check_eq("rst_rd_pc", rd_pc, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // PC match without wrap: six entries 0x00..0x14, trigger in slot 3.
    capture(2'd0, 32'h0C, 2, 32'h0, 32'h1000, -1, 30, 100);
    check_eq("pc_trig_slot", trig_index, 3);
    drain(0, 1000);

    // Wrap: eighteen retires, last eight 0x28..0x44 kept, trigger lands in slot 0.
    capture(2'd0, 32'h40, 1, 32'h0, 32'h2000, -1, 30, 100);
    check_eq("wrap_count", count, 8);
    check_eq("wrap_flag", wrapped, 1);
    drain(1, 1000);

    // Immediate trigger with no post window: one beat that is also the last.
    capture(2'd3, 32'h0, 0, 32'h100, 32'hDEAD, -1, 30, 100);
    check_eq("imm_pc", rd_pc, 32'h100);
    check_eq("imm_result", rd_result, 32'hDEAD);
    drain(2, 1000);

    // Re-arm in the middle of the post window; stale entries must never appear.
    capture(2'd0, 32'h208, 5, 32'h200, 32'h3000, -1, 4, 100);
    check_eq("abort_in_post", state, 2);
    capture(2'd1, 32'h4005, 2, 32'h400, 32'h4000, -1, 30, 70);
    drain(2, 1000);

    // Reset during readout.
    capture(2'd2, 32'h0, 3, 32'h600, 32'h5000, 4, 30, 80);
    drain(0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_rd_state", state, 0);
    check_eq("rst_rd_valid2", rd_valid, 0);
    check_eq("rst_rd_count", count, 0);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;

    // Randomized captures across all trigger modes and post lengths.
    for (int it = 0; it < 10; it++) begin
      int mode, post, tk;
      logic [31:0] pcb, resb, val;
      mode = $urandom_range(0, 3);
      post = $urandom_range(0, DEPTH - 1);
      tk   = $urandom_range(0, 20);
      pcb  = $urandom & 32'hFFFF_FFFC;
      resb = $urandom;
      val  = (mode == 0) ? pcb + 32'(4 * tk) : resb + 32'(tk);
      capture(2'(mode), val, post, pcb, resb, tk, 40, $urandom_range(40, 100));
      drain($urandom_range(0, 2), 1000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Parametrised on-chip retire-trace recorder for the single-cycle core.
- Samples per-instruction PC, instruction word, ALU result and flags (zero/carry/negative/overflow) into a circular buffer while armed.
- Fires on a selectable trigger, captures a programmable post-trigger window, then drains oldest-first over a valid/ready port.
- Sits beside the core, fed by its retire signals; read out by a debug UART/JTAG bridge.

Parameters:
XLEN, 32, width of PC/instruction/result fields
DEPTH, 16, buffer entries; power of two, >=4
AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
arm  in  1  single-cycle pulse; (re)starts capture from any state
trig_mode  in  2  00 PC==trig_value, 01 result==trig_value, 10 external, 11 immediate
trig_value  in  XLEN  compare value for modes 00/01
trig_ext  in  1  external trigger, qualified by retire_valid
post_count  in  AW  entries captured after the trigger entry (0..DEPTH-1); sampled on arm
retire_valid  in  1  one instruction retired this cycle
retire_pc  in  XLEN  PC of retiring instruction
retire_instr  in  XLEN  instruction word
retire_result  in  XLEN  ALU result
retire_flags  in  4  {zero,carry,negative,overflow}
rd_valid  out  1  readout entry available
rd_ready  in  1  consumer accepts entry
rd_pc, rd_instr, rd_result  out  XLEN each  readout fields
rd_flags  out  4  readout flags
rd_last  out  1  current beat is final entry
state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 READ
count  out  AW+1  valid entries held, saturates at DEPTH
trig_index  out  AW  buffer slot of trigger entry
wrapped  out  1  oldest entries overwritten

Behaviour:
- Reset: state=IDLE; count, trig_index, wrapped, rd_valid, rd_last, all rd_* data = 0; write/read pointers 0. Reset mid-operation aborts capture/readout the same edge.
- IDLE: retire inputs ignored.
- arm: next state ARMED from any state. Clears wr_ptr, count, wrapped. Latches post_count and trig_mode/trig_value. A retire in the arm cycle is not captured. arm beats any other event in that cycle.
- ARMED: each retire_valid writes {pc,instr,result,flags} at wr_ptr, wr_ptr+1 mod DEPTH. count+1 saturating at DEPTH; wrapped=1 on first write with count==DEPTH.
- Trigger is evaluated on the same retire, and the trigger entry is always written. trig_index = slot written.
  - If latched post_count==0: go to READ.
  - Otherwise: go to POST with remaining=post_count.
- POST: each retire writes as in ARMED and decrements remaining. The write that takes remaining to 0 moves to READ. Retires in READ are not captured.
- READ entry: rd_ptr = wrapped ? wr_ptr : 0; left = count. rd_valid=1 from the first cycle in READ.
- rd_* fields are combinational from array[rd_ptr]. They are held stable while rd_valid & !rd_ready.
- Transfer on rd_valid & rd_ready: rd_ptr+1 mod DEPTH, left-1. rd_last = (left==1).
- After the last transfer: IDLE, rd_valid=0 next cycle. count keeps its value until the next arm/rst.
- When rd_valid=0, rd_* data = 0.
- Flag/field widths are passed through unchanged; no arithmetic beyond pointer wrap.

Decomposition:
- Package trace_pkg:
  - state encodings
  - trig_mode constants
  - flag bit positions
  - ENTRY_W = 3*XLEN+4 as a function of XLEN
- Sub-module trace_ram: DEPTH x ENTRY_W flop array, one synchronous write port, one asynchronous read port.
- FSM, pointers and trigger compare live in trace_capture_buffer.

Test Plan:
- Reset: rst=1 two cycles → state=00, rd_valid=0, count=0, wrapped=0.
- PC match, no wrap (DEPTH=8):
  - Stimulus: mode 00, trig_value=0x0C, post_count=2; retire PCs 0x00..0x18 step 4.
  - Expect: trig_index=3; READ after 0x14; 6 beats 0x00..0x14 with rd_last on 0x14; 0x18 absent.
- Wrap (DEPTH=8):
  - Stimulus: mode 00, trig 0x40, post 1; PCs 0x00..0x44 step 4.
  - Expect: count=8, wrapped=1, trig_index=0; readout 0x28..0x44 in order.
- Backpressure: rd_ready pattern 1,0,0,1,1… → fields stable while low; no duplicated or dropped entries versus the written sequence.
- Immediate mode, post_count=0: first retire (PC 0x100, result 0xDEAD) → single beat with rd_last=1, then IDLE.
- Abort cases:
  - arm pulse mid-POST → count=0, state ARMED, prior entries never read.
  - rst mid-READ → rd_valid=0 and state IDLE the next cycle.
